// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus a WIDTH-cycle
// shift-add multiplier behind a start/busy/done handshake, registered N/Z/C/V flags.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             ck,
  input  logic             res,
  input  logic [WIDTH-1:0] Lbus,
  input  logic [WIDTH-1:0] Rbus,
  input  logic [3:0]       OP,
  input  logic             start,
  output logic [WIDTH-1:0] Obus,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_NOP = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                         OP_SAR = 4'd8, OP_MUL = 4'd9;
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t r_state, w_next;

  logic [WIDTH-1:0]   r_obus;
  logic [3:0]         r_flags;
  logic               r_done;
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_nxt;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  logic [SHW-1:0]     w_amt;
  logic [WIDTH:0]     w_sum, w_sh;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v, w_wr;

  assign Obus  = r_obus;
  assign flags = r_flags;
  assign done  = r_done;
  assign busy  = (r_state == S_MUL);
  assign w_amt = Rbus[SHW-1:0];
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge ck or negedge res) begin
    if (!res) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start && OP == OP_MUL) w_next = S_MUL;
      S_MUL:  if (r_cnt == LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Single-cycle result; w_wr=0 for NOP, MUL and undefined codes.
  always_comb begin
    w_sum = '0;
    w_sh  = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_wr  = 1'b1;
    case (OP)
      OP_ADD: begin
        w_sum = {1'b0, Lbus} + {1'b0, Rbus};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (Lbus[MSB] == Rbus[MSB]) && (w_res[MSB] != Lbus[MSB]);
      end
      OP_SUB: begin
        w_sum = {1'b0, Lbus} + {1'b0, ~Rbus} + (WIDTH+1)'(1);
        w_res = w_sum[WIDTH-1:0];
        w_c   = ~w_sum[WIDTH];
        w_v   = (Lbus[MSB] != Rbus[MSB]) && (w_res[MSB] != Lbus[MSB]);
      end
      OP_AND: w_res = Lbus & Rbus;
      OP_OR:  w_res = Lbus | Rbus;
      OP_XOR: w_res = Lbus ^ Rbus;
      // One guard bit beyond the data catches the last bit shifted out.
      OP_SHL: begin
        w_sh  = {1'b0, Lbus} << w_amt;
        w_res = w_sh[WIDTH-1:0];
        w_c   = w_sh[WIDTH];
      end
      OP_SHR: begin
        w_sh  = {Lbus, 1'b0} >> w_amt;
        w_res = w_sh[WIDTH:1];
        w_c   = w_sh[0];
      end
      OP_SAR: begin
        w_sh  = $signed({Lbus, 1'b0}) >>> w_amt;
        w_res = w_sh[WIDTH:1];
        w_c   = w_sh[0];
      end
      default: w_wr = 1'b0;
    endcase
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      r_obus   <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          if (OP == OP_MUL) begin
            r_mcand  <= {{WIDTH{1'b0}}, Lbus};
            r_mplier <= Rbus;
            r_acc    <= '0;
            r_cnt    <= '0;
          end else begin
            r_done <= 1'b1;
            if (w_wr) begin
              r_obus  <= w_res;
              r_flags <= {w_res[MSB], (w_res == '0), w_c, w_v};
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_obus  <= w_acc_nxt[WIDTH-1:0];
            r_flags <= {w_acc_nxt[MSB], (w_acc_nxt[WIDTH-1:0] == '0),
                        (w_acc_nxt[2*WIDTH-1:WIDTH] != '0), 1'b0};
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle successor to the single-cycle ALU. Adds a configurable datapath width, registered N/Z/C/V flags, shift operations and a shift-add multiplier, all behind a start/busy/done handshake. Sits between the register-file read buses (Lbus/Rbus) and the result bus (Obus). The controller issues one operation per handshake and stalls on busy.

## Interface
- WIDTH, 16, datapath width; legal values 8..64.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from Rbus.

- ck  in  1  clock; all state changes on the rising edge.
- res  in  1  reset, asynchronous, active-low.
- Lbus  in  WIDTH  left operand.
- Rbus  in  WIDTH  right operand; Rbus[SHW-1:0] is the shift amount for shifts.
- OP  in  4  opcode (macros in define.v):
  - `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NOP`.
  - New codes `OP_SHL`, `OP_SHR`, `OP_SAR`, `OP_MUL`, added to define.v at unused values.
- start  in  1  request; sampled only on edges where busy=0.
- Obus  out  WIDTH  registered result.
- flags  out  4  registered {N,Z,C,V}.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse; result and flags valid.

## Operation
- FSM states:
  - IDLE: accepts start.
  - MUL: counts WIDTH iterations.
- Start in IDLE with a single-cycle op (ADD, SUB, AND, OR, XOR, SHL, SHR, SAR):
  - Obus and flags are written on that edge.
  - done=1 for the following cycle.
  - State stays IDLE.
- Start with NOP: Obus and flags hold; done still pulses.
- Start with MUL:
  - Lbus, Rbus and OP are latched on the accept edge; later input changes are ignored.
  - State goes to MUL; busy=1.
  - Shift-add processes one multiplier bit per cycle.
  - After WIDTH iterations: Obus = product[WIDTH-1:0], flags written, busy=0, done pulses, state returns to IDLE.
- start while busy=1 is ignored and not queued.
- Undefined OP codes behave as NOP.
- Arithmetic: modulo 2^WIDTH.
  - SUB = Lbus + ~Rbus + 1.
  - SHL and SHR fill with 0; SAR fills with Lbus[WIDTH-1].
- Flags:
  - N = Obus[WIDTH-1] and Z = (Obus==0) for every result-writing op.
  - C:
    - ADD: carry out.
    - SUB: borrow, i.e. 1 when Lbus < Rbus unsigned.
    - Shifts: last bit shifted out; 0 if the shift amount is 0.
    - Logic ops: 0.
    - MUL: 1 if product[2*WIDTH-1:WIDTH] != 0.
  - V:
    - ADD and SUB: signed overflow.
    - All other ops: 0.
- Reset (res=0), asynchronous and effective in any state, including mid-multiply:
  - Obus=0, flags=0, busy=0, done=0.
  - FSM goes to IDLE; the multiply in flight is discarded.

## Timing
- Single-cycle ops:
  - Latency is 1 edge.
  - Back-to-back starts on consecutive edges are legal; done stays high through a run of them.
- MUL, with the accept edge at T0:
  - busy is high from after T0 through the edge T0+WIDTH.
  - Result, flags and done=1 appear after edge T0+WIDTH; busy is low in that same cycle.
  - The earliest next accept is edge T0+WIDTH+1.
- done is 0 in every cycle not directly following a completion edge.
- Outputs change only on the rising edge of ck or on the falling edge of res.
- Release of res is synchronous to ck in the system. Start is honoured on the first rising edge that sees res=1.

## Test plan
- Reset:
  - Drive res=0 for 1 cycle mid-run.
  - Required: Obus=0000, flags=0, busy=0, done=0, with no clock edge needed.
- ADD, WIDTH=16:
  - 0006+0003 -> 0009, flags 0000.
  - 0006+FFFD -> 0003, C=1.
  - 7FFF+0001 -> 8000, N=1, V=1.
  - done pulses after each.
- SUB:
  - 0006-0003 -> 0003.
  - 0003-0006 -> FFFD, N=1, C=1.
  - 0005-0005 -> 0000, Z=1.
- Logic and shifts (L=0006, R=0003):
  - AND -> 0002, OR -> 0007, XOR -> 0005.
  - SHL 8001 by 1 -> 0002, C=1.
  - SHR 8000 by 4 -> 0800.
  - SAR 8000 by 4 -> F800, N=1.
  - NOP leaves Obus unchanged.
- MUL:
  - 0006*0003 -> 0012 after exactly 16 cycles of busy, then a 1-cycle done pulse.
  - 0100*0100 -> 0000, Z=1, C=1.
  - Start pulses and operand changes during busy do not alter the result.
- Reset mid-MUL:
  - Drop res at cycle 5 of the multiply.
  - Required: busy=0 and Obus=0000 immediately; no done pulse.
  - A following ADD 0001+0001 returns 0002 with 1-cycle latency.
